// File: rtl/lemonpc_pkg.sv
// Shared LemonPC core types and constants.
// popcount lets checkers compare incremental counters against a bit vector.
package lemonpc_pkg;

   localparam int REG_ADDR_W = 5;
   localparam int XLEN       = 32;

   typedef logic [REG_ADDR_W-1:0] reg_idx_t;
   typedef logic [XLEN-1:0]       xlen_t;

   // Vectors wider than 256 bits are not expected (ADDR_WIDTH <= 8).
   function automatic int popcount(input logic [255:0] v);
      int n;
      n = 0;
      for (int i = 0; i < 256; i++) begin
         n += int'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for the register file: tracks which registers still
// await a writeback and keeps an incrementally updated busy count.
module rf_scoreboard
   import lemonpc_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int ZERO_REG   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          flush,
   input  logic                          iss_en,
   input  logic [ADDR_WIDTH-1:0]         iss_addr,
   input  logic                          wa_en,
   input  logic [ADDR_WIDTH-1:0]         wa_addr,
   input  logic                          wb_en,
   input  logic [ADDR_WIDTH-1:0]         wb_addr,
   output logic [(2**ADDR_WIDTH)-1:0]    busy,
   output logic [ADDR_WIDTH:0]           busy_cnt
);

   localparam int DEPTH   = 2**ADDR_WIDTH;
   localparam int CW      = ADDR_WIDTH + 1;
   localparam int MAX_CNT = (ZERO_REG != 0) ? DEPTH - 1 : DEPTH;

   logic [DEPTH-1:0] busy_q, busy_d, set_vec, clr_vec;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             rise, fall_a, fall_b;

   always_comb begin
      set_vec = '0;
      clr_vec = '0;
      if (iss_en && !flush && !((ZERO_REG != 0) && (iss_addr == '0))) begin
         set_vec[iss_addr] = 1'b1;
      end
      if (wa_en) clr_vec[wa_addr] = 1'b1;
      if (wb_en) clr_vec[wb_addr] = 1'b1;

      // Set wins over clear: a fresh issue supersedes the retiring producer.
      busy_d = flush ? '0 : ((busy_q & ~clr_vec) | set_vec);
      if (ZERO_REG != 0) busy_d[0] = 1'b0;

      rise   = |(set_vec & ~busy_q);
      fall_a = wa_en && busy_q[wa_addr] && !set_vec[wa_addr];
      fall_b = wb_en && busy_q[wb_addr] && !set_vec[wb_addr] &&
               !(wa_en && (wa_addr == wb_addr));
      cnt_d  = flush ? '0 : (cnt_q + CW'(rise) - CW'(fall_a) - CW'(fall_b));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
         cnt_q  <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (int'(cnt_q) == popcount(256'(busy_q)));
         assert (int'(cnt_q) <= MAX_CNT);
      end
   end

   assign busy     = busy_q;
   assign busy_cnt = cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-read, dual-write register file with optional write bypass, hardwired
// zero register and an attached busy-bit scoreboard for hazard detection.
module regfile_sb
   import lemonpc_pkg::*;
#(
   parameter int ADDR_WIDTH = REG_ADDR_W,
   parameter int DATA_WIDTH = XLEN,
   parameter int NREAD      = 2,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NREAD*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NREAD*DATA_WIDTH-1:0]   rd_data,
   output logic [NREAD-1:0]              rd_busy,
   input  logic                          wa_en,
   input  logic [ADDR_WIDTH-1:0]         wa_addr,
   input  logic [DATA_WIDTH-1:0]         wa_data,
   input  logic                          wb_en,
   input  logic [ADDR_WIDTH-1:0]         wb_addr,
   input  logic [DATA_WIDTH-1:0]         wb_data,
   input  logic                          iss_en,
   input  logic [ADDR_WIDTH-1:0]         iss_addr,
   input  logic                          flush,
   output logic [ADDR_WIDTH:0]           busy_cnt
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0]      busy_vec;
   logic                  wa_store, wb_store, wa_live, wb_live;

   assign wa_store = wa_en && !((ZERO_REG != 0) && (wa_addr == '0));
   assign wb_store = wb_en && !((ZERO_REG != 0) && (wb_addr == '0));

   // Reset also masks the bypass path so reads are clean while held in reset.
   assign wa_live  = wa_en && rst_n;
   assign wb_live  = wb_en && rst_n;

   // Port B is written last so it wins a same-index collision.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         if (wa_store) mem_q[wa_addr] <= wa_data;
         if (wb_store) mem_q[wb_addr] <= wb_data;
      end
   end

   always_comb begin
      rd_data = '0;
      rd_busy = '0;
      for (int k = 0; k < NREAD; k++) begin
         logic [ADDR_WIDTH-1:0] ra;
         logic [DATA_WIDTH-1:0] d;
         logic                  b;
         ra = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
         d  = mem_q[ra];
         b  = busy_vec[ra];
         if (BYPASS != 0) begin
            if (wb_live && (wb_addr == ra)) begin
               d = wb_data;
               b = 1'b0;
            end else if (wa_live && (wa_addr == ra)) begin
               d = wa_data;
               b = 1'b0;
            end
         end
         if ((ZERO_REG != 0) && (ra == '0)) begin
            d = '0;
            b = 1'b0;
         end
         rd_data[k*DATA_WIDTH +: DATA_WIDTH] = d;
         rd_busy[k]                          = b;
      end
   end

   rf_scoreboard #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG)
   ) u_sb (
      .clk      (clk),
      .rst_n    (rst_n),
      .flush    (flush),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .wa_en    (wa_en),
      .wa_addr  (wa_addr),
      .wb_en    (wb_en),
      .wb_addr  (wb_addr),
      .busy     (busy_vec),
      .busy_cnt (busy_cnt)
   );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a bypassing and a non-bypassing instance share one
// stimulus stream and are checked every cycle against an array-based model.
module tb_regfile_sb;

   logic        clk;
   logic        rst_n;
   logic [9:0]  rd_addr;
   logic        wa_en, wb_en, iss_en, flush;
   logic [4:0]  wa_addr, wb_addr, iss_addr;
   logic [31:0] wa_data, wb_data;

   logic [63:0] rd_data_b, rd_data_n;
   logic [1:0]  rd_busy_b, rd_busy_n;
   logic [5:0]  cnt_b, cnt_n;

   int checks;
   int errors;

   // Model: architectural register values and busy flags after the last edge.
   logic [31:0] m_reg  [32];
   bit          m_busy [32];

   regfile_sb #(.BYPASS(1)) dut_b (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_b),
      .rd_busy(rd_busy_b), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .iss_en(iss_en),
      .iss_addr(iss_addr), .flush(flush), .busy_cnt(cnt_b)
   );

   regfile_sb #(.BYPASS(0)) dut_n (
      .clk(clk), .rst_n(rst_n), .rd_addr(rd_addr), .rd_data(rd_data_n),
      .rd_busy(rd_busy_n), .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
      .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .iss_en(iss_en),
      .iss_addr(iss_addr), .flush(flush), .busy_cnt(cnt_n)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking helpers ----------------
   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int model_cnt();
      int n;
      n = 0;
      for (int i = 0; i < 32; i++) n += int'(m_busy[i]);
      return n;
   endfunction

   task automatic exp_read(input logic [4:0] a, input bit byp,
                           output logic [31:0] d, output logic b);
      if (!rst_n || a == 5'd0) begin
         d = 32'h0; b = 1'b0;
      end else if (byp && wb_en && wb_addr == a) begin
         d = wb_data; b = 1'b0;
      end else if (byp && wa_en && wa_addr == a) begin
         d = wa_data; b = 1'b0;
      end else begin
         d = m_reg[a]; b = m_busy[a];
      end
   endtask

   // ---------------- compare process and model update ----------------
   always begin
      logic [31:0] d;
      logic        b;
      logic [4:0]  a;
      @(negedge clk);
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) begin
            m_reg[i] = 32'h0; m_busy[i] = 1'b0;
         end
      end
      for (int p = 0; p < 2; p++) begin
         a = rd_addr[p*5 +: 5];
         exp_read(a, 1'b1, d, b);
         chk($sformatf("byp_data%0d", p), rd_data_b[p*32 +: 32], d);
         chk($sformatf("byp_busy%0d", p), 32'(rd_busy_b[p]), 32'(b));
         exp_read(a, 1'b0, d, b);
         chk($sformatf("nob_data%0d", p), rd_data_n[p*32 +: 32], d);
         chk($sformatf("nob_busy%0d", p), 32'(rd_busy_n[p]), 32'(b));
      end
      chk("byp_cnt", 32'(cnt_b), 32'(model_cnt()));
      chk("nob_cnt", 32'(cnt_n), 32'(model_cnt()));
      @(posedge clk);
      if (rst_n) begin
         if (wa_en && wa_addr != 5'd0) m_reg[wa_addr] = wa_data;
         if (wb_en && wb_addr != 5'd0) m_reg[wb_addr] = wb_data;
         if (flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
         end else begin
            if (wa_en) m_busy[wa_addr] = 1'b0;
            if (wb_en) m_busy[wb_addr] = 1'b0;
            if (iss_en && iss_addr != 5'd0) m_busy[iss_addr] = 1'b1;
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wa_en = 1'b0; wb_en = 1'b0; iss_en = 1'b0; flush = 1'b0;
   endtask

   task automatic mid();
      @(negedge clk);
      #1;
   endtask

   task automatic wr_a(input logic [4:0] a, input logic [31:0] d);
      wa_en = 1'b1; wa_addr = a; wa_data = d;
   endtask

   task automatic wr_b(input logic [4:0] a, input logic [31:0] d);
      wb_en = 1'b1; wb_addr = a; wb_data = d;
   endtask

   task automatic issue(input logic [4:0] a);
      iss_en = 1'b1; iss_addr = a;
   endtask

   task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
      rd_addr = {a1, a0};
   endtask

   // ---------------- directed stimulus with literal expectations ----------------
   initial begin
      checks = 0; errors = 0;
      rst_n = 1'b0;
      rd_addr = '0; wa_addr = '0; wb_addr = '0; iss_addr = '0;
      wa_data = '0; wb_data = '0;
      idle();
      tick(); tick();
      mid();
      chk("lit_reset_cnt", 32'(cnt_b), 32'd0);
      rst_n = 1'b1;
      tick();

      // x5 written, then reset mid-stream with a competing write and issue.
      wr_a(5'd5, 32'hDEADBEEF); rd(5'd5, 5'd0);
      mid();
      chk("lit_x5_byp", rd_data_b[31:0], 32'hDEADBEEF);
      chk("lit_x5_nob", rd_data_n[31:0], 32'h0);
      tick(); idle();
      mid();
      chk("lit_x5_stored", rd_data_n[31:0], 32'hDEADBEEF);
      tick();
      rst_n = 1'b0; wr_a(5'd5, 32'h1111); issue(5'd5);
      mid();
      chk("lit_rst_data", rd_data_b[31:0], 32'h0);
      tick(); idle();
      rst_n = 1'b1;
      mid();
      chk("lit_rst_x5", rd_data_n[31:0], 32'h0);
      chk("lit_rst_busy", 32'(rd_busy_n[0]), 32'd0);
      chk("lit_rst_cnt2", 32'(cnt_n), 32'd0);
      tick();

      // Same-cycle bypass vs registered read.
      wr_a(5'd3, 32'h1234); rd(5'd3, 5'd0);
      mid();
      chk("lit_bypass", rd_data_b[31:0], 32'h1234);
      chk("lit_nobypass", rd_data_n[31:0], 32'h0);
      tick(); idle();
      mid();
      chk("lit_nobypass_next", rd_data_n[31:0], 32'h1234);
      tick();

      // Dual-write collision and distinct dual writes.
      wr_a(5'd7, 32'hAAAA); wr_b(5'd7, 32'hBBBB); rd(5'd0, 5'd7);
      mid();
      chk("lit_coll_byp", rd_data_b[63:32], 32'hBBBB);
      tick(); idle();
      mid();
      chk("lit_coll_x7", rd_data_n[63:32], 32'hBBBB);
      tick();
      wr_a(5'd8, 32'd1); wr_b(5'd9, 32'd2);
      tick(); idle(); rd(5'd8, 5'd9);
      mid();
      chk("lit_x8", rd_data_n[31:0], 32'd1);
      chk("lit_x9", rd_data_n[63:32], 32'd2);
      tick();

      // Scoreboard set, set-beats-clear, clear by port B.
      issue(5'd4); rd(5'd4, 5'd0);
      mid();
      chk("lit_iss_same", 32'(rd_busy_b[0]), 32'd0);
      tick(); idle();
      mid();
      chk("lit_iss_busy", 32'(rd_busy_n[0]), 32'd1);
      chk("lit_iss_cnt", 32'(cnt_b), 32'd1);
      tick();
      issue(5'd4); wr_a(5'd4, 32'h44);
      tick(); idle();
      mid();
      chk("lit_setwins", 32'(rd_busy_n[0]), 32'd1);
      chk("lit_setwins_cnt", 32'(cnt_n), 32'd1);
      tick();
      wr_b(5'd4, 32'h55);
      mid();
      chk("lit_wb_byp_busy", 32'(rd_busy_b[0]), 32'd0);
      chk("lit_wb_nob_busy", 32'(rd_busy_n[0]), 32'd1);
      tick(); idle();
      mid();
      chk("lit_wb_clear", 32'(rd_busy_n[0]), 32'd0);
      chk("lit_wb_cnt", 32'(cnt_n), 32'd0);
      chk("lit_wb_data", rd_data_n[31:0], 32'h55);
      tick();

      // Zero register.
      wr_a(5'd0, 32'hFFFF); issue(5'd0); rd(5'd0, 5'd0);
      mid();
      chk("lit_x0_byp", rd_data_b[31:0], 32'h0);
      tick(); idle();
      mid();
      chk("lit_x0_data", rd_data_n[31:0], 32'h0);
      chk("lit_x0_busy", 32'(rd_busy_n[0]), 32'd0);
      chk("lit_x0_cnt", 32'(cnt_n), 32'd0);
      tick();

      // Flush with a simultaneous issue.
      for (int i = 1; i <= 3; i++) begin
         issue(5'(i));
         tick();
      end
      idle();
      mid();
      chk("lit_cnt3", 32'(cnt_b), 32'd3);
      tick();
      flush = 1'b1; issue(5'd6); rd(5'd1, 5'd6);
      tick(); idle();
      mid();
      chk("lit_flush_cnt", 32'(cnt_b), 32'd0);
      chk("lit_flush_x6", 32'(rd_busy_n[1]), 32'd0);
      chk("lit_flush_x1", 32'(rd_busy_n[0]), 32'd0);
      tick();

      // Two clears in one cycle.
      issue(5'd10); tick(); issue(5'd11); tick(); idle();
      wr_a(5'd10, 32'hA0); wr_b(5'd11, 32'hB0); rd(5'd10, 5'd11);
      tick(); idle();
      mid();
      chk("lit_dual_clear_cnt", 32'(cnt_n), 32'd0);
      tick();

      // Fill every register and the whole scoreboard.
      for (int i = 1; i < 32; i++) begin
         wr_b(5'(i), 32'(i * 3 + 1)); issue(5'(i)); rd(5'(i), 5'(i - 1));
         tick();
      end
      idle(); issue(5'd0);
      tick(); idle(); rd(5'd31, 5'd17);
      mid();
      chk("lit_full_cnt", 32'(cnt_b), 32'd31);
      chk("lit_x31", rd_data_n[31:0], 32'd94);
      chk("lit_x17", rd_data_n[63:32], 32'd52);
      tick();
      flush = 1'b1;
      tick(); idle();
      mid();
      chk("lit_full_flush", 32'(cnt_n), 32'd0);
      tick(); tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
